// File: rtl/sample_ram_pkg.sv
// rtl/sample_ram_pkg.sv - shared state type, default sizes and max-address helper for the sample RAM responder
package sample_ram_pkg;

    localparam int DEF_ADDR_W   = 10;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_READ_LAT = 2;

    typedef enum logic [1:0] {
        ST_INIT      = 2'd0,
        ST_IDLE      = 2'd1,
        ST_READ_WAIT = 2'd2,
        ST_READ_HOLD = 2'd3
    } state_t;

    // Highest word address of a 2^addr_w deep memory.
    function automatic logic [31:0] max_ram_addr(input int unsigned addr_w);
        return (32'd1 << addr_w) - 32'd1;
    endfunction

endpackage

// File: rtl/sample_ram_bram.sv
// rtl/sample_ram_bram.sv - simple dual-port storage, one write port and one registered read port, no reset
module sample_ram_bram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Write port and always-enabled synchronous read port; no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/sample_ram_responder.sv
// rtl/sample_ram_responder.sv - request/ack RAM responder; SAMPLE_RAM_CLEAR_ON_INIT_EN enables zero-fill during INIT
module sample_ram_responder
    import sample_ram_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int READ_LAT = DEF_READ_LAT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    input  logic              write_enable,
    input  logic              read_request,
    input  logic              read_ack,
    output logic [DATA_W-1:0] data_out,
    output logic              rdy,
    output logic              rd_data_pres,
    output logic [ADDR_W-1:0] max_ram_address
);

    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(max_ram_addr(ADDR_W));
    localparam logic [2:0]        LAT_LAST = 3'(READ_LAT - 1);

    state_t            state_q;
    logic              rdy_q;
    logic              rd_data_pres_q;
    logic [DATA_W-1:0] data_out_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        lat_q;
    logic              init_done_q;
`ifdef SAMPLE_RAM_CLEAR_ON_INIT_EN
    logic [ADDR_W-1:0] init_addr_q;
`endif

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [ADDR_W-1:0] ram_raddr;
    logic [DATA_W-1:0] ram_rdata;

    assign max_ram_address = MAX_ADDR;
    assign rdy             = rdy_q;
    assign rd_data_pres    = rd_data_pres_q;
    assign data_out        = data_out_q;

    // RAM port steering: init zero-fill or IDLE writes; read address follows the request in IDLE so the
    // word is already in the read register by the first READ_WAIT edge, then holds the latched address.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = address;
        ram_wdata = data_in;
        ram_raddr = addr_q;
        if (state_q == ST_IDLE) begin
            ram_we    = write_enable;
            ram_raddr = address;
        end
`ifdef SAMPLE_RAM_CLEAR_ON_INIT_EN
        if (state_q == ST_INIT) begin
            ram_we    = !init_done_q;
            ram_waddr = init_addr_q;
            ram_wdata = '0;
        end
`endif
    end

    sample_ram_bram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_bram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // Responder FSM with registered rdy / rd_data_pres / data_out, latency counter and init sequencing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_INIT;
            rdy_q          <= 1'b0;
            rd_data_pres_q <= 1'b0;
            data_out_q     <= '0;
            addr_q         <= '0;
            lat_q          <= '0;
            init_done_q    <= 1'b0;
`ifdef SAMPLE_RAM_CLEAR_ON_INIT_EN
            init_addr_q    <= '0;
`endif
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (init_done_q) begin
                        state_q <= ST_IDLE;
                        rdy_q   <= 1'b1;
                    end else begin
`ifdef SAMPLE_RAM_CLEAR_ON_INIT_EN
                        init_addr_q <= init_addr_q + 1'b1;
                        if (init_addr_q == MAX_ADDR) begin
                            init_done_q <= 1'b1;
                        end
`else
                        init_done_q <= 1'b1;
`endif
                    end
                end
                ST_IDLE: begin
                    // A simultaneous write wins; the read is dropped and must be retried.
                    if (read_request && !write_enable) begin
                        addr_q  <= address;
                        lat_q   <= '0;
                        state_q <= ST_READ_WAIT;
                        rdy_q   <= 1'b0;
                    end
                end
                ST_READ_WAIT: begin
                    if (lat_q == LAT_LAST) begin
                        state_q        <= ST_READ_HOLD;
                        rd_data_pres_q <= 1'b1;
                        data_out_q     <= ram_rdata;
                    end else begin
                        lat_q <= lat_q + 3'd1;
                    end
                end
                ST_READ_HOLD: begin
                    if (read_ack) begin
                        state_q        <= ST_IDLE;
                        rd_data_pres_q <= 1'b0;
                        data_out_q     <= '0;
                        rdy_q          <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_ram_responder.sv
// tb/tb_sample_ram_responder.sv - self-checking bench for sample_ram_responder (honours SAMPLE_RAM_CLEAR_ON_INIT_EN)
module tb_sample_ram_responder;

    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 8;
    localparam int READ_LAT = 2;
    localparam int DEPTH    = 1 << ADDR_W;
`ifdef SAMPLE_RAM_CLEAR_ON_INIT_EN
    localparam int INIT_CYC = DEPTH;
`else
    localparam int INIT_CYC = 1;
`endif

    localparam int OP_WR   = 0;
    localparam int OP_RD   = 1;
    localparam int OP_BOTH = 2;
    localparam int OP_POKE = 3;

    typedef struct {
        int op;
        int addr;
        int data;
        int hold;
        int exp;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] address = '0;
    logic [DATA_W-1:0] data_in = '0;
    logic              write_enable = 1'b0;
    logic              read_request = 1'b0;
    logic              read_ack = 1'b0;
    logic [DATA_W-1:0] data_out;
    logic              rdy;
    logic              rd_data_pres;
    logic [ADDR_W-1:0] max_ram_address;

    always #5 clk = ~clk;

    sample_ram_responder #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .READ_LAT (READ_LAT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .address         (address),
        .data_in         (data_in),
        .write_enable    (write_enable),
        .read_request    (read_request),
        .read_ack        (read_ack),
        .data_out        (data_out),
        .rdy             (rdy),
        .rd_data_pres    (rd_data_pres),
        .max_ram_address (max_ram_address)
    );

    int tests = 0;
    int fails = 0;

    logic [DATA_W-1:0] model_mem [DEPTH];
    bit                known [DEPTH];
    int                known_list [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        known_list.delete();
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i] = '0;
            known[i] = 1'b1;
            known_list.push_back(i);
        end
    endtask

    task automatic assert_reset_checks();
        reset = 1'b1;
        write_enable = 1'b0;
        read_request = 1'b0;
        read_ack = 1'b0;
        #1;
        check("reset_rdy", rdy, 0);
        check("reset_pres", rd_data_pres, 0);
        check("reset_dout", data_out, 0);
        check("reset_max", max_ram_address, 32'h3FF);
    endtask

    task automatic release_reset();
        int n;
        int pres_seen;
        step();
        step();
        reset = 1'b0;
        n = 0;
        pres_seen = 0;
        do begin
            step();
            n++;
            if (rd_data_pres) pres_seen++;
        end while (!rdy && n < DEPTH + 20);
        check("init_rdy_cycle", n, INIT_CYC + 1);
        check("init_no_pres", pres_seen, 0);
        check("init_dout", data_out, 0);
        check("init_max", max_ram_address, 32'h3FF);
`ifdef SAMPLE_RAM_CLEAR_ON_INIT_EN
        model_clear();
`endif
    endtask

    task automatic do_write(input int a, input int d, input bit both);
        address = ADDR_W'(a);
        data_in = DATA_W'(d);
        write_enable = 1'b1;
        read_request = both;
        step();
        write_enable = 1'b0;
        read_request = 1'b0;
        model_mem[a] = DATA_W'(d);
        if (!known[a]) begin
            known[a] = 1'b1;
            known_list.push_back(a);
        end
        check("wr_rdy", rdy, 1);
        check("wr_pres", rd_data_pres, 0);
        if (both) begin
            step();
            check("both_no_read_pres", rd_data_pres, 0);
            check("both_rdy", rdy, 1);
        end
    endtask

    // poke: drive write/read/ack in the first waiting cycle and write/read during hold; all must be ignored
    task automatic do_read(input int a, input int exp, input int hold, input bit poke);
        int n;
        address = ADDR_W'(a);
        read_request = 1'b1;
        step();
        read_request = 1'b0;
        check("rd_rdy_drop", rdy, 0);
        check("rd_wait_dout", {rd_data_pres, data_out}, 0);
        if (poke) begin
            write_enable = 1'b1;
            data_in = ~DATA_W'(exp);
            read_request = 1'b1;
            read_ack = 1'b1;
        end
        n = 0;
        do begin
            step();
            n++;
            write_enable = 1'b0;
            read_request = 1'b0;
            read_ack = 1'b0;
        end while (!rd_data_pres && n < 20);
        check("rd_latency", n, READ_LAT);
        check("rd_data", {rd_data_pres, data_out}, {1'b1, DATA_W'(exp)});
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                write_enable = 1'b1;
                read_request = 1'b1;
                address = ADDR_W'(a);
                data_in = ~DATA_W'(exp);
            end
            step();
            write_enable = 1'b0;
            read_request = 1'b0;
            check("rd_hold", {rd_data_pres, data_out, rdy}, {1'b1, DATA_W'(exp), 1'b0});
        end
        read_ack = 1'b1;
        step();
        read_ack = 1'b0;
        check("rd_ack_clear", {rd_data_pres, data_out, rdy}, {1'b0, DATA_W'(0), 1'b1});
    endtask

    vec_t vecs [14];

    initial begin
        int r;
        int a;
        int idx;

        vecs[0]  = '{OP_WR,   'h012, 'hA5, 0, 0};
        vecs[1]  = '{OP_RD,   'h012, 0,    5, 'hA5};
        vecs[2]  = '{OP_BOTH, 'h020, 'h3C, 0, 0};
        vecs[3]  = '{OP_RD,   'h020, 0,    0, 'h3C};
        vecs[4]  = '{OP_WR,   'h001, 'h11, 0, 0};
        vecs[5]  = '{OP_POKE, 'h001, 0,    2, 'h11};
        vecs[6]  = '{OP_RD,   'h001, 0,    1, 'h11};
        vecs[7]  = '{OP_WR,   'h3FF, 'h5A, 0, 0};
        vecs[8]  = '{OP_RD,   'h3FF, 0,    0, 'h5A};
        vecs[9]  = '{OP_WR,   'h000, 'hC3, 0, 0};
        vecs[10] = '{OP_RD,   'h000, 0,    3, 'hC3};
        vecs[11] = '{OP_WR,   'h012, 'h7E, 0, 0};
        vecs[12] = '{OP_RD,   'h012, 0,    0, 'h7E};
        vecs[13] = '{OP_RD,   'h3FF, 0,    2, 'h5A};

        for (int i = 0; i < DEPTH; i++) begin
            known[i] = 1'b0;
            model_mem[i] = '0;
        end

        assert_reset_checks();
        release_reset();

`ifdef SAMPLE_RAM_CLEAR_ON_INIT_EN
        for (int i = 0; i < 16; i++) begin
            do_read(i, 0, 0, 1'b0);
        end
`endif

        for (int i = 0; i < 14; i++) begin
            case (vecs[i].op)
                OP_WR:   do_write(vecs[i].addr, vecs[i].data, 1'b0);
                OP_BOTH: do_write(vecs[i].addr, vecs[i].data, 1'b1);
                OP_POKE: do_read(vecs[i].addr, vecs[i].exp, vecs[i].hold, 1'b1);
                default: do_read(vecs[i].addr, vecs[i].exp, vecs[i].hold, 1'b0);
            endcase
        end

        read_ack = 1'b1;
        step();
        read_ack = 1'b0;
        check("idle_ack_ignored", {rdy, rd_data_pres, data_out}, {1'b1, 1'b0, DATA_W'(0)});

        address = 'h012;
        read_request = 1'b1;
        step();
        read_request = 1'b0;
        step();
        step();
        check("pre_reset_hold", rd_data_pres, 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_hold", {rdy, rd_data_pres, data_out}, 0);
        release_reset();
        do_read('h012, model_mem['h012], 1, 1'b0);

        address = 'h3FF;
        read_request = 1'b1;
        step();
        read_request = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_wait", {rdy, rd_data_pres, data_out}, 0);
        release_reset();

        for (int t = 0; t < 400; t++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 3 || known_list.size() == 0) begin
                a = int'($urandom_range(0, DEPTH - 1));
                do_write(a, int'($urandom_range(0, 255)), ($urandom_range(0, 4) == 0));
            end else if (r <= 8) begin
                idx = int'($urandom_range(0, known_list.size() - 1));
                a = known_list[idx];
                do_read(a, int'(model_mem[a]), int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
            end else begin
                read_ack = 1'b1;
                step();
                read_ack = 1'b0;
                check("rand_idle_ack", {rdy, rd_data_pres}, 2'b10);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sample_ram_responder.md
SAMPLE_RAM_RESPONDER -- requirements
Module: sample_ram_responder

Interface
REQ-001 Parameter ADDR_W, default 10, SHALL set the address width; depth is 2^ADDR_W words.
REQ-002 Parameter DATA_W, default 8, SHALL set the sample word width.
REQ-003 Parameter READ_LAT, default 2, range 1..7, SHALL set cycles from read acceptance to rd_data_pres assertion.
REQ-004 clk  input  1  sole clock; all logic rising-edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 address  input  ADDR_W  word address for write or read request.
REQ-007 data_in  input  DATA_W  write data.
REQ-008 write_enable  input  1  single-cycle write request.
REQ-009 read_request  input  1  single-cycle read request.
REQ-010 read_ack  input  1  initiator consumed data_out.
REQ-011 data_out  output  DATA_W  read data, valid while rd_data_pres=1.
REQ-012 rdy  output  1  responder idle and able to accept a request.
REQ-013 rd_data_pres  output  1  read data valid, held until read_ack.
REQ-014 max_ram_address  output  ADDR_W  constant 2^ADDR_W-1.

Function
REQ-015 FSM states SHALL be INIT, IDLE, READ_WAIT, READ_HOLD; rdy=1 only in IDLE.
REQ-016 INIT SHALL transition to IDLE per REQ-035/REQ-036.
REQ-017 In IDLE, write_enable=1 SHALL store data_in at address on that edge; state remains IDLE, rdy stays 1.
REQ-018 In IDLE, read_request=1 with write_enable=0 SHALL latch address and enter READ_WAIT; rdy drops next cycle.
REQ-019 In IDLE, write_enable and read_request both 1 SHALL perform the write only; the read is dropped and the initiator SHALL retry.
REQ-020 READ_WAIT SHALL count READ_LAT cycles, then enter READ_HOLD with data_out=word at latched address and rd_data_pres=1.
REQ-021 READ_HOLD SHALL hold data_out and rd_data_pres stable until read_ack=1; next cycle rd_data_pres=0 and state=IDLE.
REQ-022 read_ack when rd_data_pres=0 SHALL be ignored.
REQ-023 write_enable or read_request outside IDLE SHALL be ignored (no store, no queueing).
REQ-024 Read of an address written in the same IDLE cycle is impossible per REQ-019; a read accepted the cycle after a write SHALL return the new data.
REQ-025 Address space SHALL be fully decoded; no wrap or out-of-range case exists.
REQ-026 data_out SHALL be 0 outside READ_HOLD.

Reset
REQ-027 reset=1 SHALL immediately force state=INIT, rdy=0, rd_data_pres=0, data_out=0, latency counter=0.
REQ-028 Reset during READ_WAIT or READ_HOLD SHALL abort the read with no data presented after release.
REQ-029 Without CLEAR_ON_INIT_EN, memory contents SHALL NOT be reset.
REQ-030 max_ram_address SHALL be valid during and after reset.

Configuration
REQ-031 Macro SAMPLE_RAM_CLEAR_ON_INIT_EN SHALL select zero-fill on init.
REQ-035 With macro defined: INIT SHALL write 0 to addresses 0..2^ADDR_W-1, one per cycle, then enter IDLE; rdy rises 2^ADDR_W+1 cycles after reset deasserts.
REQ-036 Without macro: INIT SHALL last exactly one cycle; rdy rises 2 cycles after reset deasserts.

Structure
REQ-037 Shared package sample_ram_pkg SHALL hold the state encoding type, the default ADDR_W/DATA_W/READ_LAT constants, and the max-address function.
REQ-038 Storage SHALL be a sub-module sample_ram_bram: one write port, one synchronous read port, no reset, inferable as block RAM.
REQ-039 The FSM, latency counter, and init address counter SHALL reside in sample_ram_responder.

Verification
REQ-040 Reset release, macro undefined -> rdy=1 at cycle 2, rd_data_pres=0, max_ram_address=0x3FF.
REQ-041 Write 0xA5 at 0x012, then read 0x012 -> rd_data_pres=1 exactly READ_LAT(2) cycles after the read edge, data_out=0xA5; held 5 cycles until read_ack, then cleared the next cycle.
REQ-042 write_enable and read_request both asserted at 0x020 with data 0x3C -> memory[0x020]=0x3C, no READ_WAIT entry, rd_data_pres stays 0.
REQ-043 read_request at 0x001, then write_enable during READ_WAIT at 0x001 with 0xFF -> write ignored; subsequent read returns the prior value.
REQ-044 Reset asserted in READ_HOLD -> rd_data_pres and data_out drop to 0 asynchronously; no data presented after release.
REQ-045 Macro defined, ADDR_W=4 -> rdy rises at cycle 17; reads of 0x0..0xF return 0x00.
